instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the 10-bit instruction ROM. Owns the program counter,
//  drives the ROM address, registers each fetched word and hands it to decode
//  over a valid/ready handshake. Handles branch/jump redirects, detects HALT,
//  parks the core until restarted, and counts issued instructions.
// PARAMETERS
//  AW         10            ROM address width (PC width)
//  DW         10            instruction width
//  RESET_PC   10'd1         PC loaded on reset (program image starts at word 1)
//  HALT_WORD  10'b0010000010  encoding that terminates fetch
//  CW         16            width of issued-instruction counter
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous active-low reset
//  start           in   1   pulse: begin fetching at start_addr (IDLE/HALTED only)
//  start_addr      in   AW  PC loaded when start is accepted
//  rom_addr        out  AW  ROM read address (= current PC)
//  rom_data        in   DW  ROM read data, combinational from rom_addr
//  instr           out  DW  registered instruction to decode
//  instr_valid     out  1   instr holds a valid word
//  instr_ready     in   1   decode accepts instr this cycle
//  redirect_valid  in   1   branch/jump taken: refetch from redirect_addr
//  redirect_addr   in   AW  target PC
//  halted          out  1   1 in HALTED state
//  fetch_count     out  CW  instructions handed to decode (valid&&ready)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0,
//   halted=0, fetch_count=0. rom_addr=pc at all times.
//  States: IDLE -> FETCH on start; FETCH -> HALTED on capture of HALT_WORD;
//   HALTED -> FETCH on start. start ignored in FETCH.
//  start accepted: pc<=start_addr, instr_valid<=0, halted<=0, state<=FETCH.
//   Leaving reset without start: stay IDLE (RESET_PC used only if start_addr
//   is driven to it).
//  FETCH, load slot free (!instr_valid || instr_ready), no redirect:
//   instr<=rom_data, instr_valid<=1, pc<=pc+1 (mod 2^AW: 1023 wraps to 0).
//   Latency: first instr_valid one cycle after entering FETCH; with
//   instr_ready held 1, one instruction per cycle.
//  FETCH, slot occupied (instr_valid && !instr_ready): instr, instr_valid and
//   pc hold; no ROM word lost or duplicated.
//  redirect_valid in FETCH: highest priority. pc<=redirect_addr,
//   instr_valid<=0 (word currently presented is flushed, even if instr_ready
//   is also 1 - it counts as consumed only if valid&&ready that cycle).
//   Next cycle fetches redirect_addr. Redirect ignored in IDLE and HALTED.
//  HALT: when rom_data==HALT_WORD is captured, it is still presented to decode
//   (instr_valid=1); state<=HALTED, halted<=1 same edge, pc holds at halt
//   address+1, no further ROM captures. Once HALT word handshakes,
//   instr_valid<=0. Redirect on the capture edge wins: no halt, pc<=target.
//  fetch_count increments on every cycle with instr_valid&&instr_ready;
//   saturates at 2^CW-1; cleared only by reset.
//  start and valid&&ready same cycle (HALTED, HALT word pending): handshake
//   counted, then start applied (instr_valid<=0).
// TESTING
//  1 Reset mid-FETCH (rst_n low at arbitrary cycle) -> all outputs at reset
//    values immediately, state IDLE, no fetch until start.
//  2 start, start_addr=1, ROM = copy program, instr_ready=1 -> words of addr
//    1..8 issued back-to-back, rom_addr 1,2,3..; fetch_count=8 after 8 cycles.
//  3 instr_ready=0 for 3 cycles while instr=ROM[3] -> instr/pc frozen, then
//    ROM[4] follows ROM[3] exactly once.
//  4 redirect_valid with redirect_addr=3 while instr=ROM[9] -> ROM[9] flushed
//    (not counted), next valid instr=ROM[3].
//  5 Reach addr 10 (HALT_WORD) -> instr=0x082 valid, halted=1, rom_addr=11
//    held; after handshake instr_valid=0; redirect ignored; start(1) resumes.
//  6 start_addr=1023 -> words from 1023 then 0 (wrap), no error.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the ROM address, registers
// each fetched word for decode over valid/ready, handles redirects and HALT,
// and counts instructions handed to decode.
module instr_fetch_ctrl #(
    parameter int          AW        = 10,
    parameter int          DW        = 10,
    parameter logic [AW-1:0] RESET_PC  = 10'd1,
    parameter logic [DW-1:0] HALT_WORD = 10'b0010000010,
    parameter int          CW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic          halted,
    output logic [CW-1:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALTED
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   pc_reg, pc_next;
    logic [DW-1:0]   instr_reg, instr_next;
    logic            valid_reg, valid_next;
    logic            halted_reg, halted_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            handshake;

    assign handshake   = valid_reg && instr_ready;
    assign rom_addr    = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign halted      = halted_reg;
    assign fetch_count = count_reg;

    // State and datapath registers; async reset returns everything to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            instr_reg  <= '0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            instr_reg  <= instr_next;
            valid_reg  <= valid_next;
            halted_reg <= halted_next;
            count_reg  <= count_next;
        end
    end

    // Next-state logic: start, redirect (highest priority in FETCH), load, halt.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        valid_next  = valid_reg;
        halted_next = halted_reg;
        count_next  = count_reg;

        // A consumed word always counts, even when flushed or restarted.
        if (handshake && (count_reg != {CW{1'b1}}))
            count_next = count_reg + CW'(1);

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pc_next     = start_addr;
                    valid_next  = 1'b0;
                    halted_next = 1'b0;
                    state_next  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_next    = redirect_addr;
                    valid_next = 1'b0;
                end else if (!valid_reg || instr_ready) begin
                    instr_next = rom_data;
                    valid_next = 1'b1;
                    pc_next    = pc_reg + AW'(1);
                    if (rom_data == HALT_WORD) begin
                        state_next  = ST_HALTED;
                        halted_next = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                // HALT word stays presented until decode takes it.
                if (handshake)
                    valid_next = 1'b0;
                if (start) begin
                    pc_next     = start_addr;
                    valid_next  = 1'b0;
                    halted_next = 1'b0;
                    state_next  = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: a ROM model feeds the DUT, expected
// words are queued as stimulus is planned and popped on every handshake.
module tb_instr_fetch_ctrl;

    localparam int AW = 10;
    localparam int DW = 10;
    localparam int CW = 16;
    localparam logic [DW-1:0] HALT_W = 10'b0010000010;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          halted;
    logic [CW-1:0] fetch_count;

    logic [DW-1:0] rom_mem [0:1023];
    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_addr     (start_addr),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    assign rom_data = rom_mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rom(input int addr);
        exp_q.push_back(rom_mem[addr]);
    endtask

    // Scoreboard: every handshake must match the next planned word.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                $display("issue instr=0x%03h expected=0x%03h count=%0d", instr, e, fetch_count);
                check_eq("sb_instr", 32'(instr), 32'(e));
            end
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < 1024; i++) begin
            rom_mem[i] = 10'(i * 7 + 3);
            if (rom_mem[i] == HALT_W)
                rom_mem[i] = rom_mem[i] ^ 10'd1;
        end
        rom_mem[10] = HALT_W;

        rst_n = 1'b0; start = 1'b0; start_addr = '0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        #12;
        check_eq("rst_valid",  32'(instr_valid), 32'd0);
        check_eq("rst_halted", 32'(halted),      32'd0);
        check_eq("rst_count",  32'(fetch_count), 32'd0);
        check_eq("rst_addr",   32'(rom_addr),    32'd1);
        check_eq("rst_instr",  32'(instr),       32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("idle_no_fetch", 32'(instr_valid), 32'd0);

        // Back-to-back copy program from address 1.
        for (int a = 1; a <= 8; a++) push_rom(a);
        instr_ready = 1'b1; start = 1'b1; start_addr = 10'd1;
        tick();
        start = 1'b0;
        check_eq("start_addr", 32'(rom_addr), 32'd1);
        check_eq("start_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("first_valid", 32'(instr_valid), 32'd1);
        check_eq("first_addr", 32'(rom_addr), 32'd2);
        repeat (8) tick();
        instr_ready = 1'b0;
        check_eq("count_8", 32'(fetch_count), 32'd8);
        check_eq("instr_9", 32'(instr), 32'(rom_mem[9]));

        // Redirect flushes the ROM[9] word without counting it.
        redirect_valid = 1'b1; redirect_addr = 10'd3;
        tick();
        redirect_valid = 1'b0;
        check_eq("flush_valid", 32'(instr_valid), 32'd0);
        check_eq("redir_addr",  32'(rom_addr),    32'd3);
        check_eq("flush_count", 32'(fetch_count), 32'd8);

        // Back-pressure: ROM[3] held for three cycles.
        tick();
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_instr", 32'(instr),       32'(rom_mem[3]));
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
            check_eq("stall_pc",    32'(rom_addr),    32'd4);
            tick();
        end
        for (int a = 3; a <= 10; a++) push_rom(a);
        instr_ready = 1'b1;

        // Run into the HALT word at address 10.
        guard = 0;
        while (!halted && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("halt_seen",  32'(halted),      32'd1);
        check_eq("halt_instr", 32'(instr),       32'h082);
        check_eq("halt_valid", 32'(instr_valid), 32'd1);
        check_eq("halt_pc",    32'(rom_addr),    32'd11);
        tick();
        check_eq("halt_drain", 32'(instr_valid), 32'd0);
        check_eq("count_16",   32'(fetch_count), 32'd16);
        redirect_valid = 1'b1; redirect_addr = 10'd5;
        tick();
        redirect_valid = 1'b0;
        check_eq("halt_redir_pc", 32'(rom_addr), 32'd11);
        check_eq("halt_held",     32'(halted),   32'd1);

        // Restart from HALTED.
        start = 1'b1; start_addr = 10'd1;
        tick();
        start = 1'b0;
        check_eq("resume_halted", 32'(halted),   32'd0);
        check_eq("resume_addr",   32'(rom_addr), 32'd1);
        push_rom(1);
        tick();
        tick();
        instr_ready = 1'b0;
        check_eq("resume_instr", 32'(instr), 32'(rom_mem[2]));

        // start is ignored while fetching.
        start = 1'b1; start_addr = 10'd500;
        tick();
        start = 1'b0;
        check_eq("start_ignored", 32'(rom_addr), 32'd3);

        // Asynchronous reset in the middle of FETCH.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(instr_valid), 32'd0);
        check_eq("mid_rst_count", 32'(fetch_count), 32'd0);
        check_eq("mid_rst_addr",  32'(rom_addr),    32'd1);
        check_eq("mid_rst_instr", 32'(instr),       32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("post_rst_idle", 32'(instr_valid), 32'd0);

        // PC wrap from 1023 to 0.
        push_rom(1023); push_rom(0);
        instr_ready = 1'b1; start = 1'b1; start_addr = 10'd1023;
        tick();
        start = 1'b0;
        tick();
        check_eq("wrap_pc", 32'(rom_addr), 32'd0);
        tick();
        tick();
        instr_ready = 1'b0;
        check_eq("wrap_instr", 32'(instr),       32'(rom_mem[1]));
        check_eq("wrap_count", 32'(fetch_count), 32'd2);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
